// File: rtl/sort4_ctrl_if.sv
// Bundle of the sort request/result signals and the shared comparator port.
// The slave modport is the sorter's side; the master modport is the requester/comparator side.
interface sort4_ctrl_if;
   logic        start;
   logic [15:0] data_in;
   logic [3:0]  cmp_a;
   logic [3:0]  cmp_b;
   logic        cmp_gt;
   logic        cmp_lt;
   logic        cmp_eq;
   logic        busy;
   logic        done;
   logic [15:0] data_out;
   logic [2:0]  swap_cnt;
   logic        cmp_err;

   modport slave (
      input  start, data_in, cmp_gt, cmp_lt, cmp_eq,
      output cmp_a, cmp_b, busy, done, data_out, swap_cnt, cmp_err
   );

   modport master (
      output start, data_in, cmp_gt, cmp_lt, cmp_eq,
      input  cmp_a, cmp_b, busy, done, data_out, swap_cnt, cmp_err
   );
endinterface

// File: rtl/sort4_ctrl.sv
// Bubble sort of four 4-bit elements, one pair per cycle through an external comparator.
// Stops early when a pass makes no swap; at most three passes.
module sort4_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   sort4_ctrl_if.slave       bus
);

   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0][3:0]  e_q, e_d;
   logic [1:0]       pass_q, pass_d;
   logic [1:0]       pair_q, pair_d;
   logic             flag_q, flag_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [1:0]       pair_nx;
   logic             last_pair;
   logic             swapped;
   logic             onehot;

   assign pair_nx   = pair_q + 2'd1;
   assign last_pair = (pair_q == (2'd3 - pass_q));
   // Swap flag for the pass including the pair being evaluated this cycle.
   assign swapped   = flag_q | bus.cmp_gt;
   assign onehot    = (bus.cmp_gt ^ bus.cmp_lt ^ bus.cmp_eq) &
                      ~(bus.cmp_gt & bus.cmp_lt & bus.cmp_eq);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      e_d     = e_q;
      pass_d  = pass_q;
      pair_d  = pair_q;
      flag_d  = flag_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               e_d     = bus.data_in;
               cnt_d   = 3'd0;
               err_d   = 1'b0;
               pass_d  = 2'd1;
               pair_d  = 2'd0;
               flag_d  = 1'b0;
               state_d = StCmp;
            end
         end
         StCmp: begin
            // Only cmp_gt decides a swap, which keeps equal elements in order.
            if (bus.cmp_gt) begin
               e_d[pair_q]  = e_q[pair_nx];
               e_d[pair_nx] = e_q[pair_q];
               if (cnt_q != 3'd6) begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            if (!onehot) begin
               err_d = 1'b1;
            end
            if (last_pair) begin
               if (!swapped || pass_q == 2'd3) begin
                  state_d = StDone;
               end else begin
                  pass_d = pass_q + 2'd1;
                  pair_d = 2'd0;
                  flag_d = 1'b0;
               end
            end else begin
               pair_d = pair_nx;
               flag_d = swapped;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      bus.cmp_a = 4'd0;
      bus.cmp_b = 4'd0;
      busy_d    = (state_d == StCmp);
      done_d    = (state_d == StDone);
      if (state_q == StCmp) begin
         bus.cmp_a = e_q[pair_q];
         bus.cmp_b = e_q[pair_nx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q    <= '0;
         pass_q <= 2'd0;
         pair_q <= 2'd0;
         flag_q <= 1'b0;
         cnt_q  <= 3'd0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         e_q    <= e_d;
         pass_q <= pass_d;
         pair_q <= pair_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.data_out = e_q;
   assign bus.swap_cnt = cnt_q;
   assign bus.cmp_err  = err_q;

endmodule
